fifo_rd_stream: RTL and testbench

//  Read-side engine for the handshake FIFO (wr_en/rd_en/empty/full/data_out interface).

---
 rtl/fifo_stream_pkg.sv | 13 +
 rtl/fifo_rd_skid_buf.sv | 55 +++++
 rtl/fifo_rd_stream.sv | 74 +++++++
 tb/tb_fifo_rd_stream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side stream engine.
package fifo_stream_pkg;

    typedef enum logic {
        RL_FWFT = 1'b0,
        RL_REG  = 1'b1
    } read_latency_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int SKID_DEPTH         = 2;
    localparam int OCC_WIDTH          = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer: registered head (out_*) plus one skid entry.
module fifo_rd_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [OCC_WIDTH-1:0]  occ
);

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  pop;

    assign pop = out_valid & out_ready;
    assign occ = OCC_WIDTH'(out_valid) + OCC_WIDTH'(skid_valid);

    // On a pop the skid word always goes ahead of any incoming word to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                out_data <= skid_data;
                if (in_valid) begin
                    skid_data <= in_data;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (in_valid) begin
                out_data <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_valid) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a handshake FIFO read port into a registered valid/ready stream and counts beats.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int READ_LATENCY = 0,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    localparam bit REG_READ = (READ_LATENCY == int'(RL_REG));

    logic                 inflight;
    logic                 pop;
    logic                 cap_valid;
    logic [OCC_WIDTH-1:0] occ;
    logic [OCC_WIDTH-1:0] level;

    assign pop       = m_valid & m_ready;
    assign level     = occ + OCC_WIDTH'(inflight);
    assign cap_valid = REG_READ ? inflight : fifo_rd_en;

    // Credit counts inflight words too, so the buffer can never overflow.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (rst_n && !fifo_empty) begin
            if (REG_READ) begin
                fifo_rd_en = (level < OCC_WIDTH'(SKID_DEPTH)) ||
                             (pop && (level == OCC_WIDTH'(SKID_DEPTH)));
            end else begin
                fifo_rd_en = (occ < OCC_WIDTH'(SKID_DEPTH)) || pop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= REG_READ && fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (cap_valid),
        .in_data  (fifo_data),
        .out_valid(m_valid),
        .out_data (m_data),
        .out_ready(m_ready),
        .occ      (occ)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench: word-count model of a FIFO feeding two engines (FWFT with 4-bit count, registered read).
module tb_fifo_rd_stream;

    localparam int FD   = 8;
    localparam int RING = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_ready;
    logic        fe0, fe1, re0, re1, mv0, mv1;
    logic [31:0] fd0, fd1, md0, md1, bc1;
    logic [3:0]  bc0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(32), .READ_LATENCY(0), .CNT_WIDTH(4)) u_fwft (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe0), .fifo_data(fd0), .fifo_rd_en(re0),
        .m_valid(mv0), .m_data(md0), .m_ready(m_ready), .beat_cnt(bc0));

    fifo_rd_stream #(.DATA_WIDTH(32), .READ_LATENCY(1), .CNT_WIDTH(32)) u_reg (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe1), .fifo_data(fd1), .fifo_rd_en(re1),
        .m_valid(mv1), .m_data(md1), .m_ready(m_ready), .beat_cnt(bc1));

    // Model state per engine: words written (W), read from FIFO (R), captured (C), accepted (A).
    int          W [2], R [2], C [2], A [2];
    logic [31:0] acc [2];
    logic [31:0] hist [2][RING];
    logic [31:0] fdr [2];
    logic        stall_prev [2];
    logic [31:0] prev_md [2];
    logic        lmv [2], lre [2];
    logic [31:0] lmd [2];
    logic [31:0] wq [$];
    int          wr_prob;
    int          n_checks, n_fail;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL rl%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
        end
    endtask

    task automatic chk_ge(input string name, input int inst, input int act, input int min);
        n_checks++;
        if (act < min) begin
            n_fail++;
            $display("FAIL rl%0d %s: got %0d expected at least %0d", inst, name, act, min);
        end
    endtask

    task automatic set_inputs();
        fe0 = (W[0] == R[0]);
        fd0 = fe0 ? $urandom() : hist[0][R[0] % RING];
        fe1 = (W[1] == R[1]);
        fd1 = fdr[1];
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            W[i] = 0; R[i] = 0; C[i] = 0; A[i] = 0; acc[i] = '0;
            stall_prev[i] = 1'b0;
        end
        set_inputs();
    endtask

    task automatic cycle();
        logic        pop_e [2];
        logic        re_e [2];
        logic        wr;
        logic [31:0] wdat;
        wdat = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int          occ, infl;
            logic        v_e, dmv, dre, dfe;
            logic [31:0] dmd, dbc, ebc;
            dmv = (i == 0) ? mv0 : mv1;
            dre = (i == 0) ? re0 : re1;
            dfe = (i == 0) ? fe0 : fe1;
            dmd = (i == 0) ? md0 : md1;
            dbc = (i == 0) ? {28'd0, bc0} : bc1;
            ebc = (i == 0) ? (acc[i] & 32'hF) : acc[i];
            occ  = C[i] - A[i];
            infl = R[i] - C[i];
            v_e      = (C[i] > A[i]);
            pop_e[i] = v_e && m_ready;
            if (i == 0)
                re_e[i] = rst_n && (W[i] != R[i]) && (occ < 2 || pop_e[i]);
            else
                re_e[i] = rst_n && (W[i] != R[i]) &&
                          ((occ + infl < 2) || (pop_e[i] && occ + infl == 2));
            chk("m_valid", i, {31'd0, dmv}, {31'd0, v_e});
            chk("fifo_rd_en", i, {31'd0, dre}, {31'd0, re_e[i]});
            chk("beat_cnt", i, dbc, ebc);
            if (v_e) chk("m_data", i, dmd, hist[i][A[i] % RING]);
            chk("rd_en_while_empty", i, {31'd0, dre & dfe}, 32'd0);
            if (stall_prev[i] && dmv) chk("m_data_stable", i, dmd, prev_md[i]);
            stall_prev[i] = dmv && !m_ready;
            prev_md[i] = dmd;
            lmv[i] = dmv; lre[i] = dre; lmd[i] = dmd;
        end
        wr = rst_n && (W[0] - R[0] < FD) && (W[1] - R[1] < FD) &&
             ((wq.size() > 0) || ($urandom_range(99) < wr_prob));
        if (wr) begin
            if (wq.size() > 0) wdat = wq.pop_front();
            else wdat = $urandom();
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    if (re_e[i]) begin C[i]++; R[i]++; end
                end else begin
                    if (R[i] > C[i]) C[i]++;
                    if (re_e[i]) begin fdr[i] = hist[i][R[i] % RING]; R[i]++; end
                end
                if (pop_e[i]) begin A[i]++; acc[i] = acc[i] + 1; end
                if (wr) begin hist[i][W[i] % RING] = wdat; W[i]++; end
            end
        end
        set_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("async_m_valid", 0, {31'd0, mv0}, 32'd0);
        chk("async_m_valid", 1, {31'd0, mv1}, 32'd0);
        chk("async_beat_cnt", 0, {28'd0, bc0}, 32'd0);
        chk("async_beat_cnt", 1, bc1, 32'd0);
        chk("rd_en_in_reset", 1, {31'd0, re1}, 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt_pop, cnt_re, start0, start1, k;
        bit seen [2];
        n_checks = 0; n_fail = 0;
        wr_prob = 0; m_ready = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) fdr[i] = '0;
        clear_model();
        repeat (2) cycle();
        rst_n = 1'b1;

        // Preloaded A0..A4 drain on five consecutive cycles.
        for (int i = 0; i < 5; i++) wq.push_back(32'hA0 + i);
        repeat (8) cycle();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t1_valid", 0, {31'd0, lmv[0]}, 32'd1);
            chk("t1_data", 0, lmd[0], 32'hA0 + i);
        end
        chk("t1_beat_cnt", 0, {28'd0, bc0}, 32'd5);
        cycle();
        chk("t1_valid_after_drain", 0, {31'd0, lmv[0]}, 32'd0);
        chk("t1_rd_en_after_drain", 0, {31'd0, lre[0]}, 32'd0);
        repeat (3) cycle();

        // Stall with four words queued: two reads, head holds first word.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wq.push_back(32'hB0 + i);
        cnt_re = 0;
        for (int k2 = 0; k2 < 10; k2++) begin
            cycle();
            if (lre[0]) cnt_re++;
            if (k2 >= 3) chk("t2_stall_data", 0, lmd[0], 32'hB0);
        end
        chk("t2_rd_pulses", 0, cnt_re, 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_valid", 0, {31'd0, lmv[0]}, 32'd1);
            chk("t2_data", 0, lmd[0], 32'hB0 + i);
        end

        // Registered-read engine sustains one beat per cycle from a full FIFO.
        wr_prob = 100; m_ready = 1'b0;
        repeat (12) cycle();
        m_ready = 1'b1;
        cnt_pop = 0; cnt_re = 0;
        for (int k2 = 0; k2 < 100; k2++) begin
            cycle();
            if (lmv[1]) cnt_pop++;
            if (lre[1]) cnt_re++;
        end
        chk_ge("t3_beats", 1, cnt_pop, 97);
        chk_ge("t3_rd_en", 1, cnt_re, 97);

        // Toggling ready against a randomly refilled FIFO.
        wr_prob = 70;
        start0 = A[0]; start1 = A[1];
        k = 0;
        while (((A[0] - start0) < 30000 || (A[1] - start1) < 30000) && k < 75000) begin
            m_ready = ~m_ready;
            cycle();
            k++;
        end
        chk_ge("t4_words", 0, A[0] - start0, 30000);
        chk_ge("t4_words", 1, A[1] - start1, 30000);

        wr_prob = 40;
        for (int k2 = 0; k2 < 3000; k2++) begin
            m_ready = $urandom_range(1);
            cycle();
        end

        // Reset with a full buffer; first post-reset word must come out first.
        m_ready = 1'b0; wr_prob = 100;
        repeat (6) cycle();
        do_reset();
        wr_prob = 0;
        wq.push_back(32'hC0DE0001);
        m_ready = 1'b1;
        seen[0] = 1'b0; seen[1] = 1'b0;
        for (int k2 = 0; k2 < 10; k2++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (lmv[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    chk("t5_first_word", i, lmd[i], 32'hC0DE0001);
                end
            end
        end
        chk("t5_first_seen", 0, {31'd0, seen[0]}, 32'd1);
        chk("t5_first_seen", 1, {31'd0, seen[1]}, 32'd1);

        // 4-bit beat counter wraps 15 -> 0.
        wr_prob = 100;
        seen[0] = 1'b0;
        k = 0;
        while (A[0] < 16 && k < 60) begin
            cycle();
            k++;
            if (A[0] == 15 && !seen[0]) begin
                seen[0] = 1'b1;
                chk("t6_cnt_max", 0, {28'd0, bc0}, 32'd15);
            end
        end
        chk("t6_reached", 0, A[0], 32'd16);
        chk("t6_cnt_wrap", 0, {28'd0, bc0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
